// File: rtl/ppm16_byte_packer.sv
// Packs PPM16 nibble pairs (MSB first) into framed bytes and buffers them in a
// first-word-fall-through FIFO with a valid/ready output handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for pkt_active; symbols ignored
// S_ASM_HI | expecting the high nibble of the next byte
// S_ASM_LO | high nibble held, expecting the low nibble
// S_FLUSH  | packet ended: pad a held nibble, then push stage with last=1
module ppm16_byte_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          clear,
  input  logic                          sym_valid,
  input  logic [3:0]                    sym,
  input  logic                          pkt_active,
  output logic                          byte_valid,
  output logic [7:0]                    byte_data,
  output logic                          byte_first,
  output logic                          byte_last,
  output logic                          byte_partial,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_W-1:0]              byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ASM_HI, S_ASM_LO, S_FLUSH} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       partial;
  } entry_t;

  state_t           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  entry_t           stage_q, stage_d;
  logic             stage_vld_q, stage_vld_d;
  logic             first_pend_q, first_pend_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  entry_t           mem_q [FIFO_DEPTH];

  logic             push;
  entry_t           push_entry;
  logic             asm_en;
  logic [7:0]       asm_byte;
  logic             asm_partial;
  logic             pop;
  logic             full;
  logic             wr_en;
  entry_t           head;

  // Framing FSM and staging register. The stage holds one byte back so the
  // final byte of a packet can still be tagged last when the packet ends.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    stage_d      = stage_q;
    stage_vld_d  = stage_vld_q;
    first_pend_d = first_pend_q;
    byte_count_d = byte_count_q;
    push         = 1'b0;
    push_entry   = stage_q;
    push_entry.last = 1'b0;
    asm_en       = 1'b0;
    asm_byte     = 8'h00;
    asm_partial  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pkt_active) begin
          state_d      = S_ASM_HI;
          first_pend_d = 1'b1;
          byte_count_d = '0;
          hold_vld_d   = 1'b0;
        end
      end
      S_ASM_HI: begin
        if (sym_valid) begin
          hold_d     = sym;
          hold_vld_d = 1'b1;
          state_d    = S_ASM_LO;
        end
        if (!pkt_active) state_d = S_FLUSH;
      end
      S_ASM_LO: begin
        if (sym_valid) begin
          asm_en   = 1'b1;
          asm_byte = {hold_q, sym};
          state_d  = S_ASM_HI;
        end
        if (!pkt_active) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (hold_vld_q) begin
          asm_en      = 1'b1;
          asm_byte    = {hold_q, 4'h0};
          asm_partial = 1'b1;
        end else begin
          push            = stage_vld_q;
          push_entry.last = 1'b1;
          stage_vld_d     = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (asm_en) begin
      push         = stage_vld_q;
      stage_d      = '{data: asm_byte, first: first_pend_q, last: 1'b0, partial: asm_partial};
      stage_vld_d  = 1'b1;
      first_pend_d = 1'b0;
      hold_vld_d   = 1'b0;
      if (byte_count_q != '1) byte_count_d = byte_count_q + CNT_W'(1);
    end

    if (clear) begin
      state_d      = S_IDLE;
      hold_d       = 4'h0;
      hold_vld_d   = 1'b0;
      stage_d      = '0;
      stage_vld_d  = 1'b0;
      first_pend_d = 1'b0;
      byte_count_d = '0;
      push         = 1'b0;
    end
  end

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  always_comb begin
    pop        = byte_valid & byte_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    wr_en      = push & (~full | pop);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    overflow_d = overflow_q | (push & full & ~pop);
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      hold_q       <= 4'h0;
      hold_vld_q   <= 1'b0;
      stage_q      <= '0;
      stage_vld_q  <= 1'b0;
      first_pend_q <= 1'b0;
      byte_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      stage_q      <= stage_d;
      stage_vld_q  <= stage_vld_d;
      first_pend_q <= first_pend_d;
      byte_count_q <= byte_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry;
  end

  // Storage is not reset, so the head fields are masked while empty.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    byte_valid   = (count_q != '0);
    byte_data    = byte_valid ? head.data : 8'h00;
    byte_first   = byte_valid & head.first;
    byte_last    = byte_valid & head.last;
    byte_partial = byte_valid & head.partial;
    fifo_count   = count_q;
    overflow     = overflow_q;
    byte_count   = byte_count_q;
  end

endmodule

// File: tb/tb_ppm16_byte_packer.sv
// Scoreboard bench for ppm16_byte_packer: packets are turned into expected bytes
// by a list-level reference model; a monitor checks every accepted byte.
module tb_ppm16_byte_packer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             clear = 1'b0;
  logic             sym_valid = 1'b0;
  logic [3:0]       sym = 4'h0;
  logic             pkt_active = 1'b0;
  logic             byte_ready = 1'b0;
  logic             rand_ready = 1'b0;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_first;
  logic             byte_last;
  logic             byte_partial;
  logic [$clog2(DEPTH):0] fifo_count;
  logic             overflow;
  logic [CNT_W-1:0] byte_count;

  ppm16_byte_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (clear),
    .sym_valid    (sym_valid),
    .sym          (sym),
    .pkt_active   (pkt_active),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_first   (byte_first),
    .byte_last    (byte_last),
    .byte_partial (byte_partial),
    .byte_ready   (byte_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       partial;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: pair nibbles MSB first, pad an odd tail with 0, tag first/last.
  // Only the first 'keep' bytes are expected to survive a stalled consumer.
  task automatic model_packet(input logic [3:0] nibs[$], input int keep);
    int nb;
    exp_t e;
    nb = (nibs.size() + 1) / 2;
    for (int i = 0; i < nb; i++) begin
      e.partial = (2 * i + 1 >= nibs.size());
      e.data    = {nibs[2 * i], e.partial ? 4'h0 : nibs[2 * i + 1]};
      e.first   = (i == 0);
      e.last    = (i == nb - 1);
      if (i < keep) exp_q.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none", byte_data);
        end else begin
          e = exp_q.pop_front();
          check("byte_data", 32'(byte_data), 32'(e.data));
          check("byte_first", 32'(byte_first), 32'(e.first));
          check("byte_last", 32'(byte_last), 32'(e.last));
          check("byte_partial", 32'(byte_partial), 32'(e.partial));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) byte_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sym(input logic [3:0] nib);
    sym_valid = 1'b1;
    sym       = nib;
    tick();
    sym_valid = 1'b0;
    sym       = $urandom_range(0, 15);
  endtask

  task automatic run_packet(input logic [3:0] nibs[$], input int gap_max);
    pkt_active = 1'b1;
    tick();
    foreach (nibs[i]) begin
      send_sym(nibs[i]);
      tick($urandom_range(0, gap_max));
    end
    pkt_active = 1'b0;
    tick(3);
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (byte_valid && i < 400) begin
      tick();
      i++;
    end
    check(name, 32'(byte_valid), 32'd0);
  endtask

  task automatic rand_nibs(output logic [3:0] nibs[$], input int len);
    nibs.delete();
    for (int i = 0; i < len; i++) nibs.push_back(4'($urandom_range(0, 15)));
  endtask

  initial begin
    logic [3:0] nibs[$];
    int len;

    #1 resetn = 1'b0;
    #2;
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_byte_data", 32'(byte_data), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    tick(2);
    resetn = 1'b1;
    byte_ready = 1'b1;
    tick();

    nibs = '{4'hA, 4'h5, 4'h3, 4'hC};
    model_packet(nibs, 1000);
    run_packet(nibs, 0);
    wait_drain("even_drain");
    check("even_byte_count", 32'(byte_count), 2);
    check("even_sb_empty", exp_q.size(), 0);

    nibs = '{4'h7, 4'h1, 4'hF};
    model_packet(nibs, 1000);
    run_packet(nibs, 1);
    wait_drain("odd_drain");
    check("odd_byte_count", 32'(byte_count), 2);

    nibs = '{4'h9};
    model_packet(nibs, 1000);
    run_packet(nibs, 0);
    wait_drain("single_drain");
    check("single_byte_count", 32'(byte_count), 1);
    check("single_sb_empty", exp_q.size(), 0);

    pkt_active = 1'b1;
    tick(3);
    pkt_active = 1'b0;
    tick(4);
    check("zero_byte_valid", 32'(byte_valid), 0);
    check("zero_fifo_count", 32'(fifo_count), 0);
    check("zero_byte_count", 32'(byte_count), 0);

    byte_ready = 1'b0;
    rand_nibs(nibs, 20);
    model_packet(nibs, DEPTH);
    run_packet(nibs, 0);
    check("bp_fifo_count", 32'(fifo_count), DEPTH);
    check("bp_overflow", 32'(overflow), 1);
    check("bp_byte_count", 32'(byte_count), 10);
    byte_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_overflow_sticky", 32'(overflow), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    check("clr_fifo_count", 32'(fifo_count), 0);
    check("clr_byte_count", 32'(byte_count), 0);

    byte_ready = 1'b0;
    rand_nibs(nibs, 20);
    model_packet(nibs, 1000);
    pkt_active = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) send_sym(nibs[i]);
    check("fullpop_pre_count", 32'(fifo_count), DEPTH);
    byte_ready = 1'b1;
    send_sym(nibs[19]);
    byte_ready = 1'b0;
    check("fullpop_fifo_count", 32'(fifo_count), DEPTH);
    check("fullpop_overflow", 32'(overflow), 0);
    byte_ready = 1'b1;
    pkt_active = 1'b0;
    tick(3);
    wait_drain("fullpop_drain");
    check("fullpop_overflow_end", 32'(overflow), 0);
    check("fullpop_byte_count", 32'(byte_count), 10);
    check("fullpop_sb_empty", exp_q.size(), 0);

    pkt_active = 1'b1;
    tick();
    send_sym(4'h4);
    send_sym(4'hE);
    send_sym(4'h6);
    #2 resetn = 1'b0;
    #1;
    check("async_byte_count", 32'(byte_count), 0);
    check("async_byte_valid", 32'(byte_valid), 0);
    check("async_fifo_count", 32'(fifo_count), 0);
    pkt_active = 1'b0;
    exp_q.delete();
    tick(2);
    resetn = 1'b1;
    tick();
    nibs = '{4'hB, 4'h2};
    model_packet(nibs, 1000);
    run_packet(nibs, 0);
    wait_drain("post_rst_drain");
    check("post_rst_byte_count", 32'(byte_count), 1);
    check("post_rst_sb_empty", exp_q.size(), 0);

    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 12);
      rand_nibs(nibs, len);
      model_packet(nibs, 1000);
      run_packet(nibs, 2);
      wait_drain("rand_drain");
      check("rand_byte_count", 32'(byte_count), (len + 1) / 2);
    end
    rand_ready = 1'b0;
    byte_ready = 1'b1;
    tick(2);
    check("rand_overflow", 32'(overflow), 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
